// File: rtl/ep_writeback_pkg.sv
// Shared definitions for the even-pipe writeback stage: retiring packet layout
// and field positions.
package descriptions;

    localparam int EP_PKT_W = 143;
    localparam int VAL_MSB  = 127;
    localparam int RT_LSB   = 128;
    localparam int RT_MSB   = 134;
    localparam int WREN_BIT = 135;
    localparam int UNIT_LSB = 136;
    localparam int LAT_LSB  = 139;
    localparam int ADDR_W   = 7;

    typedef struct packed {
        logic [3:0]   latency;
        logic [2:0]   unit_id;
        logic         wr_en;
        logic [6:0]   rt;
        logic [127:0] value;
    } ep_packet_t;

endpackage

// File: rtl/ep_writeback_scoreboard.sv
// Per-register pending scoreboard: set by issue, cleared by retirement,
// with a combinational busy query.
module ep_scoreboard
    import descriptions::*;
#(
    parameter int NUM_REGS = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mark_en,
    input  logic [ADDR_W-1:0] mark_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] busy_addr,
    output logic              busy
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;

    // Mark is applied after clear so a newly issued producer keeps the bit set.
    always_comb begin
        pending_next = pending;
        if (clr_en)  pending_next[clr_addr]  = 1'b0;
        if (mark_en) pending_next[mark_addr] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) pending <= '0;
        else        pending <= pending_next;
    end

    assign busy = pending[busy_addr];

endmodule

// File: rtl/ep_writeback.sv
// Even-pipe writeback: commits retiring packets into a 128x128 register file,
// serves three registered read ports. Macro EP_WB_BYPASS_EN adds write-through.
module ep_writeback
    import descriptions::*;
#(
    parameter int NUM_REGS = 128,
    parameter int DATA_W   = 128
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [EP_PKT_W-1:0] ep_packet,
    input  logic                rd_en_a,
    input  logic                rd_en_b,
    input  logic                rd_en_c,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    input  logic [ADDR_W-1:0]   rd_addr_c,
    output logic [DATA_W-1:0]   rd_data_a,
    output logic [DATA_W-1:0]   rd_data_b,
    output logic [DATA_W-1:0]   rd_data_c,
    output logic                rd_valid_a,
    output logic                rd_valid_b,
    output logic                rd_valid_c,
    input  logic                mark_en,
    input  logic [ADDR_W-1:0]   mark_addr,
    input  logic [ADDR_W-1:0]   busy_addr,
    output logic                busy,
    output logic [31:0]         retire_count
);

    ep_packet_t          pkt;
    logic [DATA_W-1:0]   regfile [NUM_REGS];
    logic [DATA_W-1:0]   rd_next_a, rd_next_b, rd_next_c;
    logic [31:0]         retire_cnt_q;
    logic                unused_pkt_fields;

    assign pkt               = ep_packet_t'(ep_packet);
    assign unused_pkt_fields = ^{pkt.unit_id, pkt.latency};

    always_comb begin
`ifdef EP_WB_BYPASS_EN
        rd_next_a = (pkt.wr_en && pkt.rt == rd_addr_a) ? pkt.value : regfile[rd_addr_a];
        rd_next_b = (pkt.wr_en && pkt.rt == rd_addr_b) ? pkt.value : regfile[rd_addr_b];
        rd_next_c = (pkt.wr_en && pkt.rt == rd_addr_c) ? pkt.value : regfile[rd_addr_c];
`else
        rd_next_a = regfile[rd_addr_a];
        rd_next_b = regfile[rd_addr_b];
        rd_next_c = regfile[rd_addr_c];
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regfile[i] <= '0;
            retire_cnt_q <= '0;
        end else if (pkt.wr_en) begin
            regfile[pkt.rt] <= pkt.value;
            retire_cnt_q    <= retire_cnt_q + 32'd1;
        end
    end

    // Data holds its last value when a port is idle; only valid drops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data_a  <= '0;
            rd_data_b  <= '0;
            rd_data_c  <= '0;
            rd_valid_a <= 1'b0;
            rd_valid_b <= 1'b0;
            rd_valid_c <= 1'b0;
        end else begin
            rd_valid_a <= rd_en_a;
            rd_valid_b <= rd_en_b;
            rd_valid_c <= rd_en_c;
            if (rd_en_a) rd_data_a <= rd_next_a;
            if (rd_en_b) rd_data_b <= rd_next_b;
            if (rd_en_c) rd_data_c <= rd_next_c;
        end
    end

    assign retire_count = retire_cnt_q;

    ep_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
        .clock     (clock),
        .reset     (reset),
        .mark_en   (mark_en),
        .mark_addr (mark_addr),
        .clr_en    (pkt.wr_en),
        .clr_addr  (pkt.rt),
        .busy_addr (busy_addr),
        .busy      (busy)
    );

endmodule

// File: tb/tb_ep_writeback.sv
// Directed bench for ep_writeback: vector table plus hand sequences for
// bypass, scoreboard priority, mid-stream reset and counter wrap.
module tb_ep_writeback;

`ifdef EP_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [142:0] ep_packet = '0;
    logic         rd_en_a = 0, rd_en_b = 0, rd_en_c = 0;
    logic [6:0]   rd_addr_a = 0, rd_addr_b = 0, rd_addr_c = 0;
    logic [127:0] rd_data_a, rd_data_b, rd_data_c;
    logic         rd_valid_a, rd_valid_b, rd_valid_c;
    logic         mark_en = 0;
    logic [6:0]   mark_addr = 0;
    logic [6:0]   busy_addr = 0;
    logic         busy;
    logic [31:0]  retire_count;

    int checks = 0;
    int failures = 0;

    ep_writeback dut (
        .clock(clock), .reset(reset), .ep_packet(ep_packet),
        .rd_en_a(rd_en_a), .rd_en_b(rd_en_b), .rd_en_c(rd_en_c),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_addr_c(rd_addr_c),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_data_c(rd_data_c),
        .rd_valid_a(rd_valid_a), .rd_valid_b(rd_valid_b), .rd_valid_c(rd_valid_c),
        .mark_en(mark_en), .mark_addr(mark_addr), .busy_addr(busy_addr),
        .busy(busy), .retire_count(retire_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         wr_en;
        logic [6:0]   rt;
        logic [127:0] val;
        logic [2:0]   rd_en;      // {c,b,a}
        logic [6:0]   addr_a, addr_b, addr_c;
        logic [127:0] exp_a, exp_b, exp_c;
        logic [2:0]   exp_valid;  // {c,b,a}
        logic [31:0]  exp_cnt;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [142:0] mk_pkt(input logic we, input logic [6:0] rt, input logic [127:0] v);
        return {4'h3, 3'h5, we, rt, v};
    endfunction

    task automatic idle_inputs();
        ep_packet = '0;
        rd_en_a = 0; rd_en_b = 0; rd_en_c = 0;
        mark_en = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_data_a"}, rd_data_a, '0);
        chk({tag, "_rd_data_b"}, rd_data_b, '0);
        chk({tag, "_rd_data_c"}, rd_data_c, '0);
        chk({tag, "_rd_valid"}, {125'd0, rd_valid_c, rd_valid_b, rd_valid_a}, '0);
        chk({tag, "_busy"}, {127'd0, busy}, '0);
        chk({tag, "_retire_count"}, {96'd0, retire_count}, '0);
    endtask

    localparam logic [127:0] P = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;

    initial begin
        // state after each row is what the next row assumes; count starts at 0
        vt[0] = '{1, 7'd5,   128'd30,     3'b000, 7'd0,   7'd0,   7'd0,
                  128'd0, 128'd0, 128'd0, 3'b000, 32'd1};
        vt[1] = '{0, 7'd0,   128'd0,      3'b111, 7'd5,   7'd5,   7'd6,
                  128'd30, 128'd30, 128'd0, 3'b111, 32'd1};
        vt[2] = '{0, 7'd7,   128'hFFFF,   3'b001, 7'd7,   7'd0,   7'd0,
                  128'd0, 128'd30, 128'd0, 3'b001, 32'd1};
        vt[3] = '{0, 7'd0,   128'd0,      3'b000, 7'd0,   7'd0,   7'd0,
                  128'd0, 128'd30, 128'd0, 3'b000, 32'd1};
        vt[4] = '{1, 7'd0,   128'hABCD,   3'b100, 7'd0,   7'd0,   7'd0,
                  128'd0, 128'd30, (BYP ? 128'hABCD : 128'd0), 3'b100, 32'd2};
        vt[5] = '{0, 7'd0,   128'd0,      3'b111, 7'd0,   7'd7,   7'd5,
                  128'hABCD, 128'd0, 128'd30, 3'b111, 32'd2};
        vt[6] = '{1, 7'd127, P,           3'b010, 7'd0,   7'd127, 7'd0,
                  128'hABCD, (BYP ? P : 128'd0), 128'd30, 3'b010, 32'd3};
        vt[7] = '{1, 7'd5,   128'd31,     3'b101, 7'd127, 7'd0,   7'd5,
                  P, (BYP ? P : 128'd0), (BYP ? 128'd31 : 128'd30), 3'b101, 32'd4};
        vt[8] = '{0, 7'd0,   128'd0,      3'b100, 7'd0,   7'd0,   7'd5,
                  P, (BYP ? P : 128'd0), 128'd31, 3'b100, 32'd4};

        // reset held with random stimulus
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ep_packet = {$urandom, $urandom, $urandom, $urandom, $urandom};
            {rd_en_a, rd_en_b, rd_en_c, mark_en} = 4'($urandom);
            rd_addr_a = 7'($urandom); rd_addr_b = 7'($urandom); rd_addr_c = 7'($urandom);
            mark_addr = 7'($urandom); busy_addr = 7'($urandom);
            step();
        end
        chk_all_zero("reset");
        idle_inputs();
        reset = 1'b1;

        foreach (vt[i]) begin
            ep_packet = mk_pkt(vt[i].wr_en, vt[i].rt, vt[i].val);
            {rd_en_c, rd_en_b, rd_en_a} = vt[i].rd_en;
            rd_addr_a = vt[i].addr_a; rd_addr_b = vt[i].addr_b; rd_addr_c = vt[i].addr_c;
            step();
            chk($sformatf("vec%0d_data_a", i), rd_data_a, vt[i].exp_a);
            chk($sformatf("vec%0d_data_b", i), rd_data_b, vt[i].exp_b);
            chk($sformatf("vec%0d_data_c", i), rd_data_c, vt[i].exp_c);
            chk($sformatf("vec%0d_valid", i), {125'd0, rd_valid_c, rd_valid_b, rd_valid_a},
                {125'd0, vt[i].exp_valid});
            chk($sformatf("vec%0d_count", i), {96'd0, retire_count}, {96'd0, vt[i].exp_cnt});
        end
        idle_inputs();

        // same-edge bypass on port b, reg 9 previously 3
        ep_packet = mk_pkt(1, 7'd9, 128'd3);
        step();
        ep_packet = mk_pkt(1, 7'd9, 128'd55);
        rd_en_b = 1; rd_addr_b = 7'd9;
        step();
        chk("bypass_same_edge", rd_data_b, BYP ? 128'd55 : 128'd3);
        ep_packet = '0;
        step();
        chk("bypass_next_edge", rd_data_b, 128'd55);
        chk("bypass_count", {96'd0, retire_count}, 128'd6);
        idle_inputs();

        // scoreboard priority
        busy_addr = 7'd12;
        #1 chk("sb_initial", {127'd0, busy}, 128'd0);
        mark_en = 1; mark_addr = 7'd12;
        step();
        chk("sb_mark", {127'd0, busy}, 128'd1);
        mark_en = 0;
        ep_packet = mk_pkt(1, 7'd12, 128'd1);
        step();
        chk("sb_retire_clear", {127'd0, busy}, 128'd0);
        mark_en = 1; mark_addr = 7'd12;
        ep_packet = mk_pkt(1, 7'd12, 128'd2);
        step();
        chk("sb_mark_wins", {127'd0, busy}, 128'd1);
        mark_addr = 7'd20;
        ep_packet = mk_pkt(1, 7'd21, 128'd4);
        step();
        busy_addr = 7'd20;
        #1 chk("sb_indep_mark", {127'd0, busy}, 128'd1);
        busy_addr = 7'd21;
        #1 chk("sb_indep_clear", {127'd0, busy}, 128'd0);
        busy_addr = 7'd12;
        #1 chk("sb_still_pending", {127'd0, busy}, 128'd1);
        chk("sb_count", {96'd0, retire_count}, 128'd9);
        idle_inputs();

        // mid-stream reset while writes and reads stream in
        for (int i = 0; i < 3; i++) begin
            ep_packet = mk_pkt(1, 7'(40 + i), 128'(100 + i));
            rd_en_a = 1; rd_addr_a = 7'd5;
            rd_en_c = 1; rd_addr_c = 7'd9;
            step();
        end
        #1 reset = 1'b0;
        #1 chk_all_zero("midreset");
        step();
        idle_inputs();
        reset = 1'b1;
        rd_en_a = 1; rd_addr_a = 7'd5;
        rd_en_b = 1; rd_addr_b = 7'd9;
        rd_en_c = 1; rd_addr_c = 7'd41;
        step();
        chk("post_reset_a", rd_data_a, '0);
        chk("post_reset_b", rd_data_b, '0);
        chk("post_reset_c", rd_data_c, '0);
        chk("post_reset_valid", {125'd0, rd_valid_c, rd_valid_b, rd_valid_a}, 128'd7);
        chk("post_reset_count", {96'd0, retire_count}, '0);
        idle_inputs();

        // counter wrap
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.retire_cnt_q;
        #1 chk("wrap_preload", {96'd0, retire_count}, {96'd0, 32'hFFFF_FFFF});
        ep_packet = mk_pkt(1, 7'd3, 128'd7);
        step();
        chk("wrap_to_zero", {96'd0, retire_count}, '0);
        ep_packet = '0;
        rd_en_a = 1; rd_addr_a = 7'd3;
        step();
        chk("wrap_data", rd_data_a, 128'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ep_writeback.md
# ep_writeback

Writeback stage at the retiring end of the even pipe. It accepts the 143-bit result packet that the even pipe drives out of its final stage and commits it to the 128 × 128-bit register file. It serves three registered read ports to issue/operand fetch, with optional same-cycle write-through bypass. A per-register pending scoreboard is set by issue and cleared by retirement.

## Interface
Parameters:
- NUM_REGS, 128, register file depth; address width is 7.
- DATA_W, 128, register width.

Ports:
- clock  in  1  sole clock; rising edge.
- reset  in  1  asynchronous, active-low; an asserted level (0) clears all state immediately.
- ep_packet  in  143  retiring even-pipe packet with fields:
  - [0:127] result value
  - [128:134] rt address
  - [135] wr_en
  - [136:138] unit id
  - [139:142] latency
- rd_en_a, rd_en_b, rd_en_c  in  1 each  read request.
- rd_addr_a, rd_addr_b, rd_addr_c  in  7 each  read address.
- rd_data_a, rd_data_b, rd_data_c  out  128 each  read data; reset 0.
- rd_valid_a, rd_valid_b, rd_valid_c  out  1 each  read data valid; reset 0.
- mark_en  in  1  issue marks rt pending.
- mark_addr  in  7  address to mark pending.
- busy_addr  in  7  scoreboard query address.
- busy  out  1  combinational pending[busy_addr]; 0 after reset.
- retire_count  out  32  number of committed writes; reset 0.

## Operation
- **Commit.** On a rising edge with ep_packet[135]=1, regfile[rt] is updated with the value field.
  - retire_count increments by 1 and wraps from 2^32-1 to 0.
  - pending[rt] is cleared.
- **wr_en=0.** The packet is ignored. There is no write, no count and no scoreboard change.
- **Reads.** On an edge with rd_en_x=1, rd_data_x is loaded and rd_valid_x is set to 1 on that same edge.
  - rd_en_x=0 drives rd_valid_x to 0, and rd_data_x holds its last value.
- **Simultaneous read and write to the same address:**
  - With bypass compiled in, the read returns the new value.
  - Otherwise it returns the old value.
  - All three ports behave identically.
- **Scoreboard.** mark_en sets pending[mark_addr].
  - If mark and retire-clear target the same address on the same edge, the mark wins and the bit stays 1, because a newer producer has been issued.
  - Different addresses update independently.
- **Register 0** is an ordinary register; there is no hardwired zero.
- **Reset.** Asserting reset at any time (including mid-stream) clears within the same cycle:
  - the whole register file, to 0
  - all pending bits
  - all rd_data and rd_valid outputs
  - retire_count
- **Reset release.** The first edge after release behaves as a normal cycle.

## Timing
- Write latency is 1 cycle: a packet present before edge N is readable by a request issued at edge N+1.
  - With bypass, it is also readable by a request at edge N.
- Read latency is 1 cycle: the request is sampled at edge N and rd_data/rd_valid are valid after edge N.
- busy is combinational from busy_addr and the current pending bits. It reflects a mark or clear on the cycle after the edge that performed it.
- There is no backpressure. A packet is accepted every cycle.

## Configuration
- Macro: EP_WB_BYPASS_EN.
- Defined: the read mux selects the incoming ep_packet value when wr_en=1 and rt equals rd_addr on the same edge.
- Undefined: the read returns the pre-write array contents. The bypass comparators are not built.

## Structure
- Shared package `descriptions`, holding:
  - EP_PKT_W=143
  - field index constants: VAL_MSB=127, RT_LSB=128, RT_MSB=134, WREN_BIT=135, UNIT_LSB=136, LAT_LSB=139
  - a packed struct typedef ep_packet_t
- One sub-module, ep_scoreboard: the 128-bit pending vector, mark/clear priority, and the busy mux.
- The register file and read ports stay in the top module.

## Test plan
- **Reset.** Hold reset=0 for 3 cycles with random stimulus → all rd_data=0, rd_valid=0, busy=0, retire_count=0. Then release.
- **Write then read.** Packet {value=30, rt=5, wr_en=1}, then rd_en_a with rd_addr_a=5 on the next edge → rd_data_a=30, rd_valid_a=1, retire_count=1.
- **Disabled write.** Packet {value=0xFFFF, rt=7, wr_en=0}, then read reg 7 → 0, retire_count unchanged.
- **Same-edge bypass.** Packet {value=55, rt=9, wr_en=1} together with rd_en_b on rd_addr_b=9, where reg 9 previously held 3 → rd_data_b=55 with the macro defined, 3 without it. A read on the following edge returns 55 in both builds.
- **Scoreboard priority.**
  - mark_addr=12 → busy=1 for busy_addr=12.
  - A retire to 12 → busy=0.
  - mark and retire to 12 on the same edge → busy=1.
- **Mid-stream reset and wrap.** Assert reset while writes stream in → everything is 0 on the next sample. Preload retire_count to 2^32-1 via forced writes, then one commit → 0.
